tube_scroller: RTL and testbench

//  Generates the five scrolling tube obstacles for Flappy Bird: x positions, gap heights, pass pulses.

---
 rtl/flappy_pkg.sv | 24 ++
 rtl/tube_lfsr.sv | 27 ++
 rtl/tube_scroller.sv | 212 +++++++++++++++++++++
 tb/tb_tube_scroller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird tube scroller.
//  - state_t   : scroller FSM states
//  - XW        : width of every x / height quantity
//  - LFSR_SEED : non-zero seed of the height LFSR
//  - lfsr_step : one Fibonacci step, taps 16,14,13,11
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int          XW        = 12;
    localparam int          NUM_TUBES = 5;
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Shift left, feedback from taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/tube_lfsr.sv
// 16-bit Fibonacci LFSR used to randomise tube gap heights.
// Ports:
//  clk     in   clock
//  rst_n   in   async active-low reset (loads LFSR_SEED)
//  advance in   step the register by one position this clock
//  value   out  current register contents (never all-zero)
module tube_lfsr
    import flappy_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/tube_scroller.sv
// Five scrolling tube obstacles: x positions, gap heights and a pass pulse.
// Scene steps once every FRAME_DIV frames (frames counted from vga_vs rises).
// Ports:
//  clk, rst_n          pixel clock, async active-low reset
//  vga_vs              vertical sync, asynchronous, synchronised here
//  start, crash        level controls for the IDLE/RUN/HALT FSM
//  tube0..4_x / _h     tube left edge and gap-top height (registered)
//  pass_pulse          1-clk pulse after a step in which a tube crossed BIRD_X
//  running             high while in RUN
module tube_scroller
    import flappy_pkg::*;
#(
    parameter int X_START      = 640,
    parameter int TUBE_SPACING = 160,
    parameter int SPEED        = 2,
    parameter int FRAME_DIV    = 4,
    parameter int BIRD_X       = 120,
    parameter int H_MIN        = 80,
    parameter int H_BITS       = 7,
    parameter int H_INIT       = 144
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vga_vs,
    input  logic          start,
    input  logic          crash,
    output logic [XW-1:0] tube0_x,
    output logic [XW-1:0] tube1_x,
    output logic [XW-1:0] tube2_x,
    output logic [XW-1:0] tube3_x,
    output logic [XW-1:0] tube4_x,
    output logic [XW-1:0] tube0_h,
    output logic [XW-1:0] tube1_h,
    output logic [XW-1:0] tube2_h,
    output logic [XW-1:0] tube3_h,
    output logic [XW-1:0] tube4_h,
    output logic          pass_pulse,
    output logic          running
);

    // Worst-case wrap sum is (SPEED-1) + 5*TUBE_SPACING - SPEED.
    if (X_START + 4 * TUBE_SPACING >= 4096 || 5 * TUBE_SPACING - 1 >= 4096 ||
        TUBE_SPACING <= SPEED || SPEED < 1 || SPEED > 15 ||
        FRAME_DIV < 1 || FRAME_DIV > 16 || H_BITS < 1 || H_BITS > 11 ||
        H_MIN + (1 << H_BITS) - 1 >= 4096 || H_INIT >= 4096 || BIRD_X >= 4096) begin : g_param_check
        $error("tube_scroller: illegal parameter combination");
    end

    localparam logic [XW-1:0] SPEED_X  = XW'(SPEED);
    localparam logic [XW-1:0] WRAP_ADD = XW'(NUM_TUBES * TUBE_SPACING - SPEED);
    localparam logic [XW-1:0] BIRD_XX  = XW'(BIRD_X);
    localparam logic [XW-1:0] H_MIN_X  = XW'(H_MIN);
    localparam logic [XW-1:0] H_INIT_X = XW'(H_INIT);
    localparam logic [3:0]    DIV_LAST = 4'(FRAME_DIV - 1);

    logic [2:0]        vs_sync_r;
    logic              frame_tick_r;
    state_t            state_r;
    state_t            state_nx;
    logic              reload_s;
    logic [3:0]        div_cnt_r;
    logic [3:0]        div_nx;
    logic              step_s;
    logic [LFSR_W-1:0] lfsr_s;
    logic              lfsr_unused_s;
    logic [XW-1:0]     tube_x_r [NUM_TUBES];
    logic [XW-1:0]     tube_h_r [NUM_TUBES];
    logic [XW-1:0]     x_nx_s   [NUM_TUBES];
    logic [XW-1:0]     h_nx_s   [NUM_TUBES];
    logic              cross_s  [NUM_TUBES];
    logic              any_cross_s;
    logic              pass_pulse_r;
    logic              running_r;

    // Sync flops reset high so a vga_vs already high at reset release is not seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_r    <= 3'b111;
            frame_tick_r <= 1'b0;
        end else begin
            vs_sync_r    <= {vs_sync_r[1:0], vga_vs};
            frame_tick_r <= vs_sync_r[1] & ~vs_sync_r[2];
        end
    end

    tube_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (frame_tick_r),
        .value   (lfsr_s)
    );

    // Only the low H_BITS feed the heights; the rest is intentionally dropped.
    assign lfsr_unused_s = ^lfsr_s;

    // FSM next state; crash is tested before start so it wins in RUN.
    always_comb begin
        state_nx = state_r;
        reload_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx = ST_RUN;
                else       state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (crash) state_nx = ST_HALT;
                else       state_nx = ST_RUN;
            end
            ST_HALT: begin
                if (start) begin
                    state_nx = ST_IDLE;
                    reload_s = 1'b1;
                end else begin
                    state_nx = ST_HALT;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                reload_s = 1'b1;
            end
        endcase
    end

    // Frame divider: counts ticks only in RUN, step on the wrapping tick.
    always_comb begin
        div_nx = div_cnt_r;
        step_s = 1'b0;
        if (state_r == ST_RUN && frame_tick_r) begin
            if (div_cnt_r == DIV_LAST) begin
                div_nx = 4'd0;
                step_s = 1'b1;
            end else begin
                div_nx = div_cnt_r + 4'd1;
            end
        end else begin
            div_nx = div_cnt_r;
        end
    end

    for (genvar i = 0; i < NUM_TUBES; i++) begin : g_lane
        localparam logic [XW-1:0] X_RST = XW'(X_START + i * TUBE_SPACING);

        // Lane next position/height; a wrapping tube draws a new height from the pre-advance LFSR.
        always_comb begin
            x_nx_s[i]  = tube_x_r[i];
            h_nx_s[i]  = tube_h_r[i];
            cross_s[i] = 1'b0;
            if (step_s) begin
                if (tube_x_r[i] >= SPEED_X) begin
                    x_nx_s[i] = tube_x_r[i] - SPEED_X;
                end else begin
                    x_nx_s[i] = tube_x_r[i] + WRAP_ADD;
                    h_nx_s[i] = H_MIN_X + XW'(lfsr_s[H_BITS-1:0]);
                end
                cross_s[i] = (tube_x_r[i] >= BIRD_XX) && (x_nx_s[i] < BIRD_XX);
            end else begin
                cross_s[i] = 1'b0;
            end
        end

        // Lane registers: reload on IDLE entry, otherwise take the stepped value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tube_x_r[i] <= X_RST;
                tube_h_r[i] <= H_INIT_X;
            end else if (reload_s) begin
                tube_x_r[i] <= X_RST;
                tube_h_r[i] <= H_INIT_X;
            end else begin
                tube_x_r[i] <= x_nx_s[i];
                tube_h_r[i] <= h_nx_s[i];
            end
        end
    end

    // Any lane crossing merges into a single pulse.
    always_comb begin
        any_cross_s = 1'b0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            any_cross_s = any_cross_s | cross_s[i];
        end
    end

    // Control registers: FSM state, divider, pass pulse and running flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= 4'd0;
            pass_pulse_r <= 1'b0;
            running_r    <= 1'b0;
        end else begin
            state_r      <= state_nx;
            div_cnt_r    <= reload_s ? 4'd0 : div_nx;
            pass_pulse_r <= any_cross_s & ~reload_s;
            running_r    <= (state_nx == ST_RUN);
        end
    end

    assign tube0_x    = tube_x_r[0];
    assign tube1_x    = tube_x_r[1];
    assign tube2_x    = tube_x_r[2];
    assign tube3_x    = tube_x_r[3];
    assign tube4_x    = tube_x_r[4];
    assign tube0_h    = tube_h_r[0];
    assign tube1_h    = tube_h_r[1];
    assign tube2_h    = tube_h_r[2];
    assign tube3_h    = tube_h_r[3];
    assign tube4_h    = tube_h_r[4];
    assign pass_pulse = pass_pulse_r;
    assign running    = running_r;

endmodule

// File: tb/tb_tube_scroller.sv
// Self-checking bench for tube_scroller: frame-level reference model feeding a
// scoreboard queue, a small table of control/frame vectors with hand-derived
// expectations, and hand-written sequences for wrap, crossing, HALT and reset.
module tb_tube_scroller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_vs;
    logic        start;
    logic        crash;
    logic [11:0] tube0_x, tube1_x, tube2_x, tube3_x, tube4_x;
    logic [11:0] tube0_h, tube1_h, tube2_h, tube3_h, tube4_h;
    logic        pass_pulse;
    logic        running;

    tube_scroller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_vs     (vga_vs),
        .start      (start),
        .crash      (crash),
        .tube0_x    (tube0_x),
        .tube1_x    (tube1_x),
        .tube2_x    (tube2_x),
        .tube3_x    (tube3_x),
        .tube4_x    (tube4_x),
        .tube0_h    (tube0_h),
        .tube1_h    (tube1_h),
        .tube2_h    (tube2_h),
        .tube3_h    (tube3_h),
        .tube4_h    (tube4_h),
        .pass_pulse (pass_pulse),
        .running    (running)
    );

    always #5 clk = ~clk;

    logic [4:0][11:0] act_x;
    logic [4:0][11:0] act_h;
    assign act_x = {tube4_x, tube3_x, tube2_x, tube1_x, tube0_x};
    assign act_h = {tube4_h, tube3_h, tube2_h, tube1_h, tube0_h};

    int tests = 0;
    int fails = 0;
    int pulse_total = 0;

    always @(negedge clk) begin
        if (pass_pulse === 1'b1) pulse_total++;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0][11:0] x;
        logic [4:0][11:0] h;
        logic             run;
        int               pulses;
    } exp_t;

    exp_t             sb_q[$];
    logic [4:0][11:0] m_x;
    logic [4:0][11:0] m_h;
    int               m_state;   // 0 idle, 1 run, 2 halt
    int               m_div;
    logic [15:0]      m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reload();
        for (int i = 0; i < 5; i++) begin
            m_x[i] = 12'(640 + 160 * i);
            m_h[i] = 12'd144;
        end
        m_div = 0;
    endtask

    task automatic model_reset();
        model_reload();
        m_state = 0;
        m_lfsr  = 16'hACE1;
    endtask

    task automatic model_frame(output logic stepped, output int pulse, output logic [15:0] lf_before);
        logic [11:0] old_x;
        logic [11:0] new_x;
        stepped   = 1'b0;
        pulse     = 0;
        lf_before = m_lfsr;
        if (m_state == 1) begin
            if (m_div == 3) begin
                m_div   = 0;
                stepped = 1'b1;
            end else begin
                m_div++;
            end
        end
        if (stepped) begin
            for (int i = 0; i < 5; i++) begin
                old_x = m_x[i];
                if (old_x >= 12'd2) begin
                    new_x = old_x - 12'd2;
                end else begin
                    new_x  = old_x + 12'd798;
                    m_h[i] = 12'd80 + {5'd0, m_lfsr[6:0]};
                end
                if (old_x >= 12'd120 && new_x < 12'd120) pulse = 1;
                m_x[i] = new_x;
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_exp(input string tag, input exp_t e);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_x%0d", tag, i), 32'(act_x[i]), 32'(e.x[i]));
            check($sformatf("%s_h%0d", tag, i), 32'(act_h[i]), 32'(e.h[i]));
        end
        check($sformatf("%s_running", tag), 32'(running), 32'(e.run));
    endtask

    // One vga_vs frame: high 3 clks, low 4 clks, covering tick, step and pass pulse.
    task automatic do_frame(input string tag, output logic stepped, output int pulse, output logic [15:0] lf_before);
        exp_t e;
        int   p0;
        model_frame(stepped, pulse, lf_before);
        e.x = m_x; e.h = m_h; e.run = (m_state == 1); e.pulses = pulse;
        sb_q.push_back(e);
        p0 = pulse_total;
        @(negedge clk) vga_vs = 1'b1;
        repeat (3) @(negedge clk);
        vga_vs = 1'b0;
        repeat (4) @(negedge clk);
        e = sb_q.pop_front();
        compare_exp(tag, e);
        check({tag, "_pulses"}, 32'(pulse_total - p0), 32'(e.pulses));
    endtask

    task automatic pulse_ctrl(input logic s, input logic c);
        exp_t e;
        @(negedge clk);
        start = s;
        crash = c;
        @(negedge clk);
        start = 1'b0;
        crash = 1'b0;
        case (m_state)
            0: if (s) m_state = 1;
            1: if (c) m_state = 2;
            2: if (s) begin m_state = 0; model_reload(); end
            default: m_state = 0;
        endcase
        e.x = m_x; e.h = m_h; e.run = (m_state == 1); e.pulses = 0;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        compare_exp("ctrl", e);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start;
        logic        crash;
        int          frames;
        logic        exp_running;
        logic [11:0] exp_x0;
        logic [11:0] exp_x4;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic        st;
        int          pl;
        logic [15:0] lfb;
        int          p0;
        logic [11:0] old_x0, old_x1;
        logic        wrapped;

        vecs[0] = '{1'b0, 1'b0, 10, 1'b0, 12'd640, 12'd1280, 0};
        vecs[1] = '{1'b1, 1'b0,  0, 1'b1, 12'd640, 12'd1280, 0};
        vecs[2] = '{1'b0, 1'b0,  8, 1'b1, 12'd636, 12'd1276, 0};
        vecs[3] = '{1'b0, 1'b0,  3, 1'b1, 12'd636, 12'd1276, 0};
        vecs[4] = '{1'b0, 1'b0,  1, 1'b1, 12'd634, 12'd1274, 0};

        rst_n  = 1'b0;
        vga_vs = 1'b0;
        start  = 1'b0;
        crash  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_x0", 32'(tube0_x), 32'd640);
        check("rst_x4", 32'(tube4_x), 32'd1280);
        check("rst_h2", 32'(tube2_h), 32'd144);
        check("rst_running", 32'(running), 32'd0);
        check("rst_pass", 32'(pass_pulse), 32'd0);

        // Table: idle frames, start, and the first steps.
        for (int v = 0; v < 5; v++) begin
            p0 = pulse_total;
            if (vecs[v].start || vecs[v].crash) pulse_ctrl(vecs[v].start, vecs[v].crash);
            for (int f = 0; f < vecs[v].frames; f++) do_frame($sformatf("vec%0d", v), st, pl, lfb);
            check($sformatf("vec%0d_running", v), 32'(running), 32'(vecs[v].exp_running));
            check($sformatf("vec%0d_x0", v), 32'(tube0_x), 32'(vecs[v].exp_x0));
            check($sformatf("vec%0d_x4", v), 32'(tube4_x), 32'(vecs[v].exp_x4));
            check($sformatf("vec%0d_pulses", v), 32'(pulse_total - p0), 32'(vecs[v].exp_pulses));
            if (v == 0) check("idle_lfsr", 32'(dut.u_lfsr.value), 32'(m_lfsr));
        end

        // Run tube0 across BIRD_X and through its wrap.
        wrapped = 1'b0;
        for (int f = 0; f < 1400 && !wrapped; f++) begin
            old_x0 = m_x[0];
            old_x1 = m_x[1];
            p0 = pulse_total;
            do_frame("scroll", st, pl, lfb);
            if (st && old_x0 == 12'd122) check("no_pass_at_120", 32'(pulse_total - p0), 32'd0);
            if (st && old_x0 == 12'd120) check("pass_120_118", 32'(pulse_total - p0), 32'd1);
            if (st && old_x0 == 12'd2)   check("x2_to_0", 32'(tube0_x), 32'd0);
            if (st && old_x0 == 12'd0) begin
                wrapped = 1'b1;
                check("wrap_x0", 32'(tube0_x), 32'd798);
                check("wrap_h0", 32'(tube0_h), 32'd80 + 32'(lfb[6:0]));
                check("wrap_x1", 32'(tube1_x), 32'(old_x1) - 32'd2);
            end
        end
        check("wrap_reached", 32'(wrapped), 32'd1);

        // Crash and start together in RUN: HALT, frozen for 20 frames.
        pulse_ctrl(1'b1, 1'b1);
        check("halt_running", 32'(running), 32'd0);
        old_x0 = tube0_x;
        for (int f = 0; f < 20; f++) do_frame("halt", st, pl, lfb);
        check("halt_frozen_x0", 32'(tube0_x), 32'(m_x[0]));
        pulse_ctrl(1'b1, 1'b0);
        check("reload_x0", 32'(tube0_x), 32'd640);
        check("reload_x4", 32'(tube4_x), 32'd1280);
        check("reload_h0", 32'(tube0_h), 32'd144);
        pulse_ctrl(1'b1, 1'b0);
        check("rerun_running", 32'(running), 32'd1);
        for (int f = 0; f < 4; f++) do_frame("rerun", st, pl, lfb);
        check("rerun_x0", 32'(tube0_x), 32'd638);

        // Asynchronous reset right as a frame tick is pending.
        @(negedge clk) vga_vs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_x0", 32'(tube0_x), 32'd640);
        check("async_x3", 32'(tube3_x), 32'd1120);
        check("async_h0", 32'(tube0_h), 32'd144);
        check("async_running", 32'(running), 32'd0);
        check("async_pass", 32'(pass_pulse), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(negedge clk) vga_vs = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_lfsr", 32'(dut.u_lfsr.value), 32'h0000ACE1);
        pulse_ctrl(1'b1, 1'b0);
        for (int f = 0; f < 3; f++) do_frame("post_rst", st, pl, lfb);
        check("post_rst_3f_x0", 32'(tube0_x), 32'd640);
        do_frame("post_rst", st, pl, lfb);
        check("post_rst_4f_x0", 32'(tube0_x), 32'd638);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
